// File: rtl/hdc_deadlock_detector_if.sv
// ----------------------------------------------------------------------------
// hdc_deadlock_detector_if
// Bundles the per-stream status flags produced by the kernel monitor top and
// consumed by the deadlock detector.
//   axis_block_sigs [N_AXIS] : 1 = channel i is stalled on its AXIS handshake
//   inst_idle_sigs  [N_AXIS] : 1 = sub-instance owning channel i is idle
//   inst_block_sigs [N_INST] : 1 = instance-level block (any bit counts)
// Modports: master drives the flags (monitor side), slave samples them
// (detector side).
// ----------------------------------------------------------------------------
interface hdc_deadlock_detector_if #(
   parameter int N_AXIS = 4,
   parameter int N_INST = 1
) ();
   logic [N_AXIS-1:0] axis_block_sigs;
   logic [N_AXIS-1:0] inst_idle_sigs;
   logic [N_INST-1:0] inst_block_sigs;

   modport master (
      output axis_block_sigs,
      output inst_idle_sigs,
      output inst_block_sigs
   );

   modport slave (
      input axis_block_sigs,
      input inst_idle_sigs,
      input inst_block_sigs
   );
endinterface

// File: rtl/hdc_deadlock_detector.sv
// ----------------------------------------------------------------------------
// hdc_deadlock_detector
// Declares the kernel deadlocked once every active stream (or an instance-level
// block) has been stuck for THRESH consecutive cycles.
//   kernel_monitor_clock : sole clock, rising edge
//   kernel_monitor_reset : asynchronous, active-low reset
//   monitor_clear        : synchronous clear of FSM, counters and captures
//   mon                  : status flags from the kernel monitor (slave modport)
//   block                : 1 while in BLOCK state (registered)
//   block_rise           : one-cycle pulse on entry to BLOCK
//   block_fall           : one-cycle pulse on exit from BLOCK to RUN
//   first_chan           : lowest-index stuck active channel captured on entry
//   inst_caused          : 1 if an instance block was present on entry
//   block_count          : number of BLOCK entries, saturating
// ----------------------------------------------------------------------------
module hdc_deadlock_detector #(
   parameter int N_AXIS = 4,
   parameter int N_INST = 1,
   parameter int THRESH = 8,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = 2
) (
   input  logic                  kernel_monitor_clock,
   input  logic                  kernel_monitor_reset,
   input  logic                  monitor_clear,
   hdc_deadlock_detector_if.slave mon,
   output logic                  block,
   output logic                  block_rise,
   output logic                  block_fall,
   output logic [IDX_W-1:0]      first_chan,
   output logic                  inst_caused,
   output logic [CNT_W-1:0]      block_count
);

   localparam int CW = $clog2(THRESH + 1);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_SUSPECT = 2'd1;
   localparam logic [1:0] ST_BLOCK   = 2'd2;

   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    CNT_LAST  = CW'(THRESH - 1);
   localparam logic [CNT_W-1:0] BCNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] BCNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BCNT_MAX  = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_nxt_s;
   logic [N_AXIS-1:0] active_s;
   logic [N_AXIS-1:0] stuck_s;
   logic              cond_s;
   logic              enter_s;
   logic              exit_s;

   // Lowest set bit index; 0 when nothing is set (instance-only cause).
   function automatic logic [IDX_W-1:0] lowest_set(input logic [N_AXIS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = IDX_ZERO;
      for (int i = N_AXIS - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Deadlock condition: all active channels stuck (and at least one active),
   // or any instance-level block. Idle channels are masked out.
   always_comb begin
      active_s = ~mon.inst_idle_sigs;
      stuck_s  = active_s & mon.axis_block_sigs;
      cond_s   = ((|active_s) & (&(stuck_s | ~active_s))) | (|mon.inst_block_sigs);
   end

   // Next-state / stuck-cycle counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_RUN: begin
            if (cond_s) begin
               state_nxt_s = ST_SUSPECT;
               cnt_nxt_s   = CNT_ONE;
            end else begin
               cnt_nxt_s   = CNT_ZERO;
            end
         end
         ST_SUSPECT: begin
            if (!cond_s) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               // cnt counts edges already seen with cond=1; this is the THRESH-th.
               state_nxt_s = ST_BLOCK;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_BLOCK: begin
            if (!cond_s) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_BLOCK;
            end
         end
         default: begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
      enter_s = (state_r != ST_BLOCK) && (state_nxt_s == ST_BLOCK);
      exit_s  = (state_r == ST_BLOCK) && (state_nxt_s == ST_RUN);
   end

   // FSM state and counter registers.
   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         state_r <= ST_RUN;
         cnt_r   <= CNT_ZERO;
      end else if (monitor_clear) begin
         state_r <= ST_RUN;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Registered status flags; a clear suppresses block_fall.
   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         block      <= 1'b0;
         block_rise <= 1'b0;
         block_fall <= 1'b0;
      end else if (monitor_clear) begin
         block      <= 1'b0;
         block_rise <= 1'b0;
         block_fall <= 1'b0;
      end else begin
         block      <= (state_nxt_s == ST_BLOCK);
         block_rise <= enter_s;
         block_fall <= exit_s;
      end
   end

   // Entry captures and saturating entry counter.
   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         first_chan  <= IDX_ZERO;
         inst_caused <= 1'b0;
         block_count <= BCNT_ZERO;
      end else if (monitor_clear) begin
         first_chan  <= IDX_ZERO;
         inst_caused <= 1'b0;
         block_count <= BCNT_ZERO;
      end else if (enter_s) begin
         first_chan  <= lowest_set(stuck_s);
         inst_caused <= |mon.inst_block_sigs;
         if (block_count != BCNT_MAX) begin
            block_count <= block_count + BCNT_ONE;
         end else begin
            block_count <= block_count;
         end
      end else begin
         first_chan  <= first_chan;
         inst_caused <= inst_caused;
         block_count <= block_count;
      end
   end

endmodule
